wash_timer: RTL and testbench

- Time base for the washing-machine controller.
- Divides the system clock down to a one-cycle pulse every second (`time_out`).
- Counts those seconds to produce a one-cycle pulse every minute (`time_out_s`).
- The system clock frequency is selected at run time from four supported values (1/2/4/8 MHz), so wall-clock timing is independent of the installed oscillator.

---
 rtl/wash_pkg.sv | 19 +
 rtl/pulse_divider.sv | 39 +++
 rtl/wash_timer.sv | 75 +++++++
 tb/tb_wash_timer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
`timescale 1ns/1ps
// Shared constants for the washing-machine time base.
// No logic; latency n/a.
// No flow control; constants only.
//
// Contents: clock-frequency select encodings and default timing constants.
package wash_pkg;

    // Clk_Freq encodings: the oscillator runs at BASE_CYCLES << Clk_Freq Hz
    localparam logic [1:0] FREQ_1M = 2'b00;
    localparam logic [1:0] FREQ_2M = 2'b01;
    localparam logic [1:0] FREQ_4M = 2'b10;
    localparam logic [1:0] FREQ_8M = 2'b11;

    // Cycles per second at the slowest oscillator, and seconds per minute
    localparam int DEF_BASE_CYCLES  = 1_000_000;
    localparam int DEF_SECS_PER_MIN = 60;

endpackage

// File: rtl/pulse_divider.sv
`timescale 1ns/1ps
// Generic modulo-(limit+1) counter with a terminal-count strobe.
// tc is combinational in the cycle the counter sits at/above limit while enabled.
// No backpressure; counts every enabled cycle.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   en        - advance enable
//   limit     - terminal count, may change at run time
//   tc        - high when an enabled edge will wrap the counter to zero
module pulse_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt;

    // >= rather than == so that lowering limit below the current count
    // wraps on the next enabled edge instead of running the full counter range
    assign tc = en && (cnt >= limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/wash_timer.sv
`timescale 1ns/1ps
// Washing-machine time base: one-cycle pulse per second and per minute.
// time_out registered one edge after the prescaler wrap; time_out_s on the same edge.
// No backpressure; free-running counters.
//
// Ports:
//   Clk        - system clock, rising edge
//   Rst        - synchronous active-high reset, clears all counting
//   Clk_Freq   - oscillator select, 00=1 MHz .. 11=8 MHz
//   time_out   - one-cycle pulse per elapsed second
//   time_out_s - one-cycle pulse per elapsed minute, coincides with a time_out
module wash_timer
    import wash_pkg::*;
#(
    parameter int BASE_CYCLES  = DEF_BASE_CYCLES,
    parameter int SECS_PER_MIN = DEF_SECS_PER_MIN,
    parameter int CNT_W        = 24,
    parameter int SEC_W        = 6
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] Clk_Freq,
    output logic       time_out,
    output logic       time_out_s
);

    localparam logic [CNT_W-1:0] BASE_W    = CNT_W'(BASE_CYCLES);
    localparam logic [SEC_W-1:0] SEC_LIMIT = SEC_W'(SECS_PER_MIN - 1);

    logic [CNT_W-1:0] cyc_limit;
    logic             cyc_tc;
    logic             sec_tc;

    // Terminal count follows Clk_Freq immediately; no restart on a change
    always_comb begin
        cyc_limit = BASE_W - CNT_W'(1);
        case (Clk_Freq)
            FREQ_1M: cyc_limit = BASE_W - CNT_W'(1);
            FREQ_2M: cyc_limit = (BASE_W << 1) - CNT_W'(1);
            FREQ_4M: cyc_limit = (BASE_W << 2) - CNT_W'(1);
            FREQ_8M: cyc_limit = (BASE_W << 3) - CNT_W'(1);
            default: cyc_limit = BASE_W - CNT_W'(1);
        endcase
    end

    // Cycle prescaler: always counting
    pulse_divider #(.W(CNT_W)) u_cyc (
        .clk   (Clk),
        .rst   (Rst),
        .en    (1'b1),
        .limit (cyc_limit),
        .tc    (cyc_tc)
    );

    // Seconds counter steps on the prescaler wrap edge itself, so its own
    // wrap lands on the same edge as the 60th second pulse
    pulse_divider #(.W(SEC_W)) u_sec (
        .clk   (Clk),
        .rst   (Rst),
        .en    (cyc_tc),
        .limit (SEC_LIMIT),
        .tc    (sec_tc)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            time_out   <= 1'b0;
            time_out_s <= 1'b0;
        end else begin
            time_out   <= cyc_tc;
            time_out_s <= sec_tc;
        end
    end

endmodule

// File: tb/tb_wash_timer.sv
`timescale 1ns/1ps
module tb_wash_timer;

    typedef struct {
        int cyc;
        bit to;
        bit tos;
    } exp_t;

    logic       Clk      = 1'b0;
    logic       Rst      = 1'b1;
    logic [1:0] Clk_Freq = 2'b11;
    logic       time_out;
    logic       time_out_s;

    int   edge_n = 0;
    int   rel    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    wash_timer #(.BASE_CYCLES(10)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Clk_Freq   (Clk_Freq),
        .time_out   (time_out),
        .time_out_s (time_out_s)
    );

    always #62.5 Clk = ~Clk;

    always @(posedge Clk) edge_n <= edge_n + 1;

    // Monitor: every cycle with an output pulse must match the next expected event
    always @(negedge Clk) begin
        if (time_out === 1'b1 || time_out_s === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: edge %0d time_out=%b time_out_s=%b, required no pulse",
                         edge_n, time_out, time_out_s);
            end else begin
                mon_e = exp_q.pop_front();
                if (edge_n != mon_e.cyc || time_out !== mon_e.to || time_out_s !== mon_e.tos) begin
                    n_bad++;
                    $display("FAIL pulse_check: got edge %0d to=%b tos=%b, required edge %0d to=%b tos=%b",
                             edge_n, time_out, time_out_s, mon_e.cyc, mon_e.to, mon_e.tos);
                end
            end
        end
    end

    task automatic expect_pulse(input int cyc, input bit tos);
        exp_t e;
        e.cyc = cyc;
        e.to  = 1'b1;
        e.tos = tos;
        exp_q.push_back(e);
    endtask

    task automatic run_until(input int cyc);
        while (edge_n < cyc) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Hold reset for n edges, check outputs are cleared, then release.
    // rel = number of the last reset edge; counting edges start at rel+1.
    task automatic apply_reset(input int n, input logic [1:0] f, input string name);
        Rst      = 1'b1;
        Clk_Freq = f;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
        n_vec++;
        if (time_out !== 1'b0 || time_out_s !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_reset_state: time_out=%b time_out_s=%b, required 0 0",
                     name, time_out, time_out_s);
        end
        Rst = 1'b0;
        rel = edge_n;
    endtask

    task automatic end_phase(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_missed: %0d expected pulses not seen, first due edge %0d, required 0 outstanding",
                     name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        // 8 MHz: second every 80 cycles, minute every 4800
        apply_reset(2, 2'b11, "p1");
        for (int k = 1; k <= 120; k++) expect_pulse(rel + 80 * k, (k % 60) == 0);
        run_until(rel + 9605);
        end_phase("p1_8m");

        // 1/2/4 MHz periods 10/20/40
        for (int f = 0; f < 3; f++) begin
            apply_reset(1, 2'(f), "p2");
            for (int k = 1; k <= 3; k++) expect_pulse(rel + (10 << f) * k, 1'b0);
            run_until(rel + 3 * (10 << f) + 5);
            end_phase("p2_period");
        end

        // 8 MHz -> 1 MHz at cyc_cnt=50: immediate short second, then 10-cycle seconds;
        // the short second still counts toward the minute
        apply_reset(1, 2'b11, "p3");
        for (int k = 1; k <= 60; k++) expect_pulse(rel + 51 + 10 * (k - 1), k == 60);
        run_until(rel + 50);
        Clk_Freq = 2'b00;
        run_until(rel + 646);
        end_phase("p3_freq_switch");

        // Reset at sec_cnt=30 on the edge that would have emitted the 31st second
        apply_reset(1, 2'b00, "p4");
        for (int k = 1; k <= 30; k++) expect_pulse(rel + 10 * k, 1'b0);
        run_until(rel + 309);
        end_phase("p4_pre_reset");
        apply_reset(1, 2'b00, "p4_mid");
        for (int k = 1; k <= 60; k++) expect_pulse(rel + 10 * k, k == 60);
        run_until(rel + 605);
        end_phase("p4_post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
